pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 19 +
 rtl/pipe_adder_if.sv | 20 ++
 rtl/pipe_adder_stage.sv | 21 ++
 rtl/pipe_adder.sv | 87 ++++++++
 tb/tb_pipe_adder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants and the stage record for the pipelined adder.
// The optional carry-out port is controlled by macro PIPE_ADDER_COUT_EN.
package pipe_adder_pkg;

  localparam int unsigned PA_WIDTH   = 32;
  localparam int unsigned PA_STAGE_W = 8;
  localparam int unsigned PA_STAGES  = PA_WIDTH / PA_STAGE_W;

  // Per-stage pipeline record at the default width: the top declares the same
  // layout against its own WIDTH so non-default builds stay consistent.
  typedef struct packed {
    logic                valid;
    logic                carry;
    logic [PA_WIDTH-1:0] sum;
    logic [PA_WIDTH-1:0] x_0;
    logic [PA_WIDTH-1:0] x_1;
  } stage_t;

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result bus of the pipelined adder.
// PIPE_ADDER_COUT_EN adds the carry-out signal to the bus.
interface pipe_adder_if #(
  parameter int unsigned WIDTH = pipe_adder_pkg::PA_WIDTH
);
  logic             req;
  logic [WIDTH-1:0] x_0;
  logic [WIDTH-1:0] x_1;
  logic [WIDTH-1:0] result;
  logic             vld;
`ifdef PIPE_ADDER_COUT_EN
  logic             cout;

  modport master (output req, x_0, x_1, input  result, vld, cout);
  modport slave  (input  req, x_0, x_1, output result, vld, cout);
`else
  modport master (output req, x_0, x_1, input  result, vld);
  modport slave  (input  req, x_0, x_1, output result, vld);
`endif
endinterface

// File: rtl/pipe_adder_stage.sv
// One STAGE_W-bit ripple slice with carry in and carry out.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int unsigned STAGE_W = PA_STAGE_W
) (
  input  logic [STAGE_W-1:0] a,
  input  logic [STAGE_W-1:0] b,
  input  logic               cin,
  output logic [STAGE_W-1:0] s,
  output logic               cout
);
  logic [STAGE_W:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{STAGE_W{1'b0}}, cin};
  end

  assign s    = total[STAGE_W-1:0];
  assign cout = total[STAGE_W];
endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder: one STAGE_W slice per stage, latency WIDTH/STAGE_W cycles.
// Macro PIPE_ADDER_COUT_EN exposes the final carry-out on the bus.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = PA_WIDTH,
  parameter int unsigned STAGE_W = PA_STAGE_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  pipe_adder_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / STAGE_W;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] x_0;
    logic [WIDTH-1:0] x_1;
  } stage_rec_t;

  if (WIDTH % STAGE_W != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGE_W");
  end

  stage_rec_t         stage_in  [STAGES];
  stage_rec_t         st_d      [STAGES];
  stage_rec_t         st_q      [STAGES];
  logic [STAGE_W-1:0] slice_sum [STAGES];
  logic               slice_cout[STAGES];

  // Stage k consumes the record registered by stage k-1; stage 1 takes the bus.
  always_comb begin
    stage_in[0].valid = bus.req;
    stage_in[0].carry = 1'b0;
    stage_in[0].sum   = '0;
    stage_in[0].x_0   = bus.x_0;
    stage_in[0].x_1   = bus.x_1;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_in[i] = st_q[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_adder_stage #(.STAGE_W(STAGE_W)) u_stage (
      .a   (stage_in[g].x_0[g*STAGE_W +: STAGE_W]),
      .b   (stage_in[g].x_1[g*STAGE_W +: STAGE_W]),
      .cin (stage_in[g].carry),
      .s   (slice_sum[g]),
      .cout(slice_cout[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      st_d[i]                             = stage_in[i];
      st_d[i].carry                       = slice_cout[i];
      st_d[i].sum[i*STAGE_W +: STAGE_W]   = slice_sum[i];
    end
  end

  // Flush only drops valid bits and outranks stall; stall freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        st_q[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        st_q[i].valid <= 1'b0;
      end
    end else if (!stall) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        st_q[i] <= st_d[i];
      end
    end
  end

  assign bus.result = st_q[STAGES-1].sum;
  assign bus.vld    = st_q[STAGES-1].valid & ~stall;
`ifdef PIPE_ADDER_COUT_EN
  assign bus.cout   = st_q[STAGES-1].carry;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: expected sums queued at acceptance, popped on vld.
module tb_pipe_adder;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic stall = 1'b0;

  pipe_adder_if #(.WIDTH(32)) bus ();

  pipe_adder #(.WIDTH(32), .STAGE_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .stall(stall),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Apply inputs for the coming edge, then settle to the falling edge for checks.
  task automatic set_in(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic f);
    bus.req = r;
    bus.x_0 = a;
    bus.x_1 = b;
    stall   = s;
    flush   = f;
    @(negedge clk);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (reset || flush) exp_q.delete();
    else if (bus.req && !stall) exp_q.push_back({1'b0, bus.x_0} + {1'b0, bus.x_1});
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b expected 0", bus.vld); end
      n_cmp++;
      if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 0", bus.result); end
      clk_edge();
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [32:0] e;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) set_in(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
      else        set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.vld !== (c == 4)) begin n_err++; $display("FAIL single_vld cycle %0d: got %b expected %b", c, bus.vld, (c == 4)); end
      if (bus.vld === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.result !== 32'h0000_0003) begin n_err++; $display("FAIL single_result: got %h expected 00000003", bus.result); end
      end
      clk_edge();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL single_left: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_carry();
    logic [32:0] e;
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      set_in(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      else if (c == 1) set_in(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      else             set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.vld !== (c == 4 || c == 5)) begin n_err++; $display("FAIL carry_vld cycle %0d: got %b expected %b", c, bus.vld, (c == 4 || c == 5)); end
      if (bus.vld === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL carry_extra cycle %0d: got result %h expected none", c, bus.result); end
        else begin
          e = exp_q.pop_front();
          if (bus.result !== e[31:0]) begin n_err++; $display("FAIL carry_result cycle %0d: got %h expected %h", c, bus.result, e[31:0]); end
`ifdef PIPE_ADDER_COUT_EN
          n_cmp++;
          if (bus.cout !== e[32]) begin n_err++; $display("FAIL carry_cout cycle %0d: got %b expected %b", c, bus.cout, e[32]); end
`endif
        end
      end
      clk_edge();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL carry_left: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    for (int c = 0; c < 16; c++) begin
      if (c < 10) set_in(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
      else        set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.vld !== (c >= 4 && c <= 13)) begin n_err++; $display("FAIL b2b_vld cycle %0d: got %b expected %b", c, bus.vld, (c >= 4 && c <= 13)); end
      if (bus.vld === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra cycle %0d: got result %h expected none", c, bus.result); end
        else begin
          e = exp_q.pop_front();
          if (bus.result !== e[31:0]) begin n_err++; $display("FAIL b2b_result cycle %0d: got %h expected %h", c, bus.result, e[31:0]); end
`ifdef PIPE_ADDER_COUT_EN
          n_cmp++;
          if (bus.cout !== e[32]) begin n_err++; $display("FAIL b2b_cout cycle %0d: got %b expected %b", c, bus.cout, e[32]); end
`endif
        end
      end
      clk_edge();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_left: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Ops in cycles 0-4 and 8-10, stall (with req held high) in cycles 5-7.
  task automatic test_stall();
    logic [32:0] e;
    logic        exp_v;
    for (int c = 0; c < 18; c++) begin
      if (c <= 4 || (c >= 8 && c <= 10)) set_in(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
      else if (c <= 7)                   set_in(1'b1, $urandom(), $urandom(), 1'b1, 1'b0);
      else                               set_in(1'b0, '0, '0, 1'b0, 1'b0);
      exp_v = (c == 4) || (c >= 8 && c <= 14);
      n_cmp++;
      if (bus.vld !== exp_v) begin n_err++; $display("FAIL stall_vld cycle %0d: got %b expected %b", c, bus.vld, exp_v); end
      if (bus.vld === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_extra cycle %0d: got result %h expected none", c, bus.result); end
        else begin
          e = exp_q.pop_front();
          if (bus.result !== e[31:0]) begin n_err++; $display("FAIL stall_result cycle %0d: got %h expected %h", c, bus.result, e[31:0]); end
        end
      end
      clk_edge();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_left: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Three ops in flight, then flush together with stall and a rejected req.
  task automatic test_flush();
    logic [32:0] e;
    for (int c = 0; c < 11; c++) begin
      if (c <= 2)      set_in(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
      else if (c == 3) set_in(1'b1, $urandom(), $urandom(), 1'b1, 1'b1);
      else if (c == 4) set_in(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
      else             set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.vld !== (c == 8)) begin n_err++; $display("FAIL flush_vld cycle %0d: got %b expected %b", c, bus.vld, (c == 8)); end
      if (bus.vld === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL flush_extra cycle %0d: got result %h expected none", c, bus.result); end
        else begin
          e = exp_q.pop_front();
          if (bus.result !== e[31:0]) begin n_err++; $display("FAIL flush_result cycle %0d: got %h expected %h", c, bus.result, e[31:0]); end
        end
      end
      clk_edge();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL flush_left: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_in_flight();
    logic [32:0] e;
    for (int c = 0; c < 5; c++) begin
      if (c <= 2) set_in(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
      else        set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.vld !== (c == 4)) begin n_err++; $display("FAIL rif_vld cycle %0d: got %b expected %b", c, bus.vld, (c == 4)); end
      if (bus.vld === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.result !== e[31:0]) begin n_err++; $display("FAIL rif_result: got %h expected %h", bus.result, e[31:0]); end
      end
      if (c < 4) clk_edge();
    end
    reset = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++;
    if (bus.vld !== 1'b0) begin n_err++; $display("FAIL rif_async_vld: got %b expected 0", bus.vld); end
    n_cmp++;
    if (bus.result !== 32'h0) begin n_err++; $display("FAIL rif_async_result: got %h expected 0", bus.result); end
    clk_edge();
    clk_edge();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.vld !== 1'b0 || bus.result !== 32'h0) begin
        n_err++;
        $display("FAIL rif_after cycle %0d: got vld=%b result=%h expected vld=0 result=0", c, bus.vld, bus.result);
      end
      clk_edge();
    end
  endtask

  initial begin
    bus.req = 1'b0;
    bus.x_0 = '0;
    bus.x_1 = '0;
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
